led_pwm_fader: RTL and testbench



---
 rtl/led_pwm_pkg.sv | 21 ++
 rtl/led_pwm_channel.sv | 62 ++++++
 rtl/led_pwm_fader.sv | 75 +++++++
 tb/tb_led_pwm_fader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_pkg.sv
// Shared constants, types and the optional gamma curve for the LED PWM fader.
// The gamma helper is only referenced when LED_PWM_FADER_GAMMA_EN is defined.
package led_pwm_pkg;

  localparam int LED_COUNT    = 8;
  localparam int PWM_BITS_DEF = 8;
  localparam int FADE_DIV_DEF = 24;

  typedef logic [PWM_BITS_DEF-1:0] duty_t;

  // Square-law perceptual map: upper half of duty*duty, with full scale pinned to full scale.
  function automatic logic [31:0] gamma_map(input logic [31:0] duty, input int unsigned bits);
    logic [31:0] max_v;
    logic [63:0] sq;
    max_v = (32'd1 << bits) - 32'd1;
    sq    = 64'(duty) * 64'(duty);
    if (duty == max_v) return max_v;
    return 32'(sq >> bits);
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: saturating duty register, optional gamma map (LED_PWM_FADER_GAMMA_EN),
// PWM compare against the shared counter, and a registered pin drive.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                step_i,
  input  logic                tgt_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o,
  output logic                busy_o
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] eff;
  logic                led_q, led_d;

  always_comb begin
    // NOTE: default first so every path assigns duty_d; a missing else would infer a latch.
    duty_d = duty_q;
    if (step_i) begin
      if (tgt_i && (duty_q != MAX)) begin
        duty_d = duty_q + PWM_BITS'(1);
      end else if (!tgt_i && (duty_q != '0)) begin
        duty_d = duty_q - PWM_BITS'(1);
      end
    end
  end

`ifdef LED_PWM_FADER_GAMMA_EN
  assign eff = PWM_BITS'(gamma_map(32'(duty_q), PWM_BITS));
`else
  assign eff = duty_q;
`endif

  // Full scale is forced high so a fully-on LED never drops out for one clock per period.
  always_comb begin
    led_d = (eff == MAX) ? 1'b1 : (pwm_cnt_i < eff);
  end

  assign busy_o = tgt_i ? (duty_q != MAX) : (duty_q != '0);

  // NOTE: reset is synchronous, so it is tested inside the clocked branch rather than listed
  // in the sensitivity list; state is updated with <= so all flops see pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pwm_fader.sv
// Eight-channel LED fader: shared PWM counter and fade-step divider driving one
// led_pwm_channel per LED. Optional square-law curve via LED_PWM_FADER_GAMMA_EN.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int FADE_DIV = FADE_DIV_DEF
) (
  input  logic                 CLK_i,
  input  logic                 RST_i,
  input  logic [LED_COUNT-1:0] LED_i,
  output logic [LED_COUNT-1:0] LED_o,
  output logic                 BUSY_o
);

  localparam int                  DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);

  logic [LED_COUNT-1:0] tgt_q, tgt_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 busy_q, busy_d;
  logic                 step;
  logic [LED_COUNT-1:0] chan_busy;

  // The divider only moves at the end of a PWM period, so a step lands on pwm_cnt == MAX
  // and the new duty takes effect from the very next period.
  always_comb begin
    tgt_d     = LED_i;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    div_cnt_d = div_cnt_q;
    step      = 1'b0;
    if (pwm_cnt_q == PWM_MAX) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        step      = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
    busy_d = |chan_busy;
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      tgt_q     <= '0;
      pwm_cnt_q <= '0;
      div_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      tgt_q     <= tgt_d;
      pwm_cnt_q <= pwm_cnt_d;
      div_cnt_q <= div_cnt_d;
      busy_q    <= busy_d;
    end
  end

  for (genvar n = 0; n < LED_COUNT; n++) begin : g_chan
    led_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk_i     (CLK_i),
      .rst_i     (RST_i),
      .step_i    (step),
      .tgt_i     (tgt_q[n]),
      .pwm_cnt_i (pwm_cnt_q),
      .led_o     (LED_o[n]),
      .busy_o    (chan_busy[n])
    );
  end

  assign BUSY_o = busy_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader at PWM_BITS=4, FADE_DIV=2 (16-clock period, step every 32).
// Expected PWM patterns follow the gamma curve when LED_PWM_FADER_GAMMA_EN is defined.
module tb_led_pwm_fader;

  logic       clk;
  logic       rst;
  logic [7:0] led_in;
  logic [7:0] led_out;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  led_pwm_fader #(
    .PWM_BITS (4),
    .FADE_DIV (2)
  ) dut (
    .CLK_i  (clk),
    .RST_i  (rst),
    .LED_i  (led_in),
    .LED_o  (led_out),
    .BUSY_o (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since the last reset release; edge 1 is the first non-reset edge.
  always @(posedge clk) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int   ticks;
    int   exp_duty;
    logic exp_busy;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // LED_o pattern over one period, bit i = sample i after the period starts at pwm_cnt 0.
  function automatic logic [15:0] exp_pattern(input int duty);
    int eff;
`ifdef LED_PWM_FADER_GAMMA_EN
    eff = (duty == 15) ? 15 : ((duty * duty) >> 4);
`else
    eff = duty;
`endif
    if (eff >= 15) return 16'hFFFF;
    return 16'((32'd1 << eff) - 1);
  endfunction

  task automatic wait_edges(input int target);
    int guard;
    guard = 0;
    while (edges < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (edges != target) begin
      checks++;
      errors++;
      $display("FAIL sync: edge count %0d expected %0d", edges, target);
    end
  endtask

  // Samples the 16 clocks that show the duty produced by step number m.
  task automatic measure(input int m, output logic [15:0] pat0, output logic [7:0] any_hi,
                         output logic busy_last);
    wait_edges(32 * m + 1);
    pat0   = '0;
    any_hi = '0;
    busy_last = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      pat0[i]   = led_out[0];
      any_hi    = any_hi | led_out;
      busy_last = busy;
    end
  endtask

  task automatic do_reset(input logic [7:0] led, input int cycles);
    @(negedge clk);
    rst    = 1'b1;
    led_in = led;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t       fade_vec[8];
  logic [15:0] pat;
  logic [7:0]  hi;
  logic        bl;
  int          max_ones;
  int          busy_cnt;
  int          led3_cnt;
  int          guard;

  initial begin
    fade_vec[0] = '{ticks: 0,  exp_duty: 0,  exp_busy: 1'b1};
    fade_vec[1] = '{ticks: 1,  exp_duty: 1,  exp_busy: 1'b1};
    fade_vec[2] = '{ticks: 2,  exp_duty: 2,  exp_busy: 1'b1};
    fade_vec[3] = '{ticks: 5,  exp_duty: 5,  exp_busy: 1'b1};
    fade_vec[4] = '{ticks: 8,  exp_duty: 8,  exp_busy: 1'b1};
    fade_vec[5] = '{ticks: 14, exp_duty: 14, exp_busy: 1'b1};
    fade_vec[6] = '{ticks: 15, exp_duty: 15, exp_busy: 1'b0};
    fade_vec[7] = '{ticks: 17, exp_duty: 15, exp_busy: 1'b0};

    rst    = 1'b1;
    led_in = 8'hFF;

    // Reset with all targets high: outputs stay low until the second edge after release.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_led_%0d", i), led_out, 0);
      check($sformatf("rst_busy_%0d", i), busy, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rel1_led", led_out, 0);
    check("rel1_busy", busy, 0);
    @(negedge clk);
    check("rel2_busy", busy, 1);

    // Fade up on channel 0 only.
    do_reset(8'h01, 3);
    for (int v = 0; v < 8; v++) begin
      measure(fade_vec[v].ticks, pat, hi, bl);
      check($sformatf("fade_pat_t%0d", fade_vec[v].ticks), pat, exp_pattern(fade_vec[v].exp_duty));
      check($sformatf("fade_others_t%0d", fade_vec[v].ticks), hi[7:1], 0);
      check($sformatf("fade_busy_t%0d", fade_vec[v].ticks), bl, fade_vec[v].exp_busy);
    end

    // Reversal at duty 7: steps back down from 7 and saturates at 0.
    do_reset(8'h01, 3);
    measure(7, pat, hi, bl);
    check("rev_pat_t7", pat, exp_pattern(7));
    max_ones = $countones(pat);
    led_in = 8'h00;
    for (int m = 8; m <= 16; m++) begin
      measure(m, pat, hi, bl);
      if ($countones(pat) > max_ones) max_ones = $countones(pat);
      check($sformatf("rev_pat_t%0d", m), pat, exp_pattern((14 - m) < 0 ? 0 : (14 - m)));
    end
    check("rev_max_highs", max_ones, $countones(exp_pattern(7)));
    check("rev_busy_end", bl, 0);

    // Short pulse on channel 3 between steps (steps at edges 544 and 576).
    wait_edges(530);
    led_in   = 8'h08;
    busy_cnt = 0;
    led3_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 4) led_in = 8'h00;
      if (busy) busy_cnt++;
      if (led_out[3]) led3_cnt++;
    end
    check("pulse_busy_blip_ok", (busy_cnt > 0 && busy_cnt <= 5) ? 1 : 0, 1);
    check("pulse_led3_during", led3_cnt, 0);
    measure(18, pat, hi, bl);
    check("pulse_led3_after", hi[3], 0);
    check("pulse_busy_after", bl, 0);

    // Reset for one clock at duty 9; fade restarts from 0 with the first step 31 clocks later.
    do_reset(8'h01, 3);
    measure(9, pat, hi, bl);
    check("mid_pat_t9", pat, exp_pattern(9));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_led", led_out, 0);
    check("mid_rst_busy", busy, 0);
    rst   = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!led_out[0] && guard < 200);
`ifdef LED_PWM_FADER_GAMMA_EN
    // Gamma keeps duty 1..3 dark; the first lit period follows duty 4 (step at edge 128).
    check("mid_first_high_edge", edges, 129);
`else
    check("mid_first_high_edge", edges, 33);
`endif
    measure(5, pat, hi, bl);
    check("mid_restart_t5", pat, exp_pattern(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
